// File: rtl/start_screen_fader_pkg.sv
// Shared types and constants for the title-screen pixel output stage:
// FSM state encoding, the 16-entry RGB palette and brightness limits.
package start_screen_pkg;

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        SHOW     = 2'd1,
        FADE_OUT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int         BRIGHT_MAX = 16;
    localparam logic [3:0] IDX_WHITE  = 4'd9;
    localparam logic [3:0] IDX_YELLOW = 4'd14;

    // 24-bit {R,G,B} per palette index.
    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'hFFFFFF, 24'h5555FF, 24'h55FF55,
        24'h55FFFF, 24'hFF5555, 24'hFFD800, 24'hFF55FF
    };

endpackage

// File: rtl/start_screen_fader_if.sv
// Pixel/sync/key inputs and RGB/status outputs of the title-screen fader.
// master: renderer/VGA/keyboard side; slave: the fader itself.
interface start_screen_fader_if;
    logic [3:0] color_idx;
    logic       blank;
    logic       vs;
    logic       start_key;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic       screen_active;
    logic       start_done;

    modport master (
        output color_idx, blank, vs, start_key,
        input  Red, Green, Blue, screen_active, start_done
    );

    modport slave (
        input  color_idx, blank, vs, start_key,
        output Red, Green, Blue, screen_active, start_done
    );
endinterface

// File: rtl/start_screen_fader_frame_tick_gen.sv
// Frame tick from the falling edge of active-low vs, plus a counter that
// emits a step pulse on every FADE_STEP-th tick. clr restarts the count
// so the first step after a state change lands FADE_STEP ticks later.
module frame_tick_gen #(
    parameter int FADE_STEP = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic vs,
    input  logic clr,
    output logic tick,
    output logic step
);

    if (FADE_STEP < 1 || FADE_STEP > 15) begin : g_bad_fade_step
        $error("FADE_STEP must be in 1..15");
    end

    localparam logic [3:0] STEP_LAST = 4'(FADE_STEP - 1);

    logic       vs_prev_p0;
    logic [3:0] step_cnt;

    assign tick = vs_prev_p0 & ~vs;
    // step must not depend on clr: clr is derived from the next state,
    // which itself depends on step.
    assign step = tick && (step_cnt == STEP_LAST);

    // Previous vs level for falling-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) vs_prev_p0 <= 1'b0;
        else          vs_prev_p0 <= vs;
    end

    // Tick counter; a state change discards any tick in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)  step_cnt <= '0;
        else if (clr)  step_cnt <= '0;
        else if (tick) step_cnt <= step ? 4'd0 : step_cnt + 4'd1;
    end

endmodule

// File: rtl/start_screen_fader.sv
// Title-screen pixel output stage: palette lookup, frame-based fade-in /
// fade-out brightness scaling, and Enter-triggered hand-off to the game.
// Optional macro START_SCREEN_BLINK_EN: blinks the yellow index while the
// title is fully shown.
module start_screen_fader
    import start_screen_pkg::*;
#(
    parameter int FADE_STEP  = 2,
    parameter int BLINK_HALF = 30
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    start_screen_fader_if.slave  bus
);

    if (BLINK_HALF < 1 || BLINK_HALF > 63) begin : g_bad_blink_half
        $error("BLINK_HALF must be in 1..63");
    end

    localparam logic [4:0] BRIGHT_TOP = 5'(BRIGHT_MAX);

    // Brightness scale: 8-bit channel times 0..16, divided by 16.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [4:0] b);
        logic [12:0] prod;
        prod = 13'(c) * 13'(b);
        return prod[11:4];
    endfunction

    state_t     state_q, state_d;
    logic [4:0] bright_q, bright_d;
    logic       start_done_q;
    logic       key_s1_p0, key_s2_p1, key_prev_p2;
    logic       key_rise;
    logic       tick, step, state_chg;
    logic       mask_yellow;
    logic [7:0] red_p0, green_p0, blue_p0;
    logic [23:0] pal;

    frame_tick_gen #(.FADE_STEP(FADE_STEP)) u_tick (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vs      (bus.vs),
        .clr     (state_chg),
        .tick    (tick),
        .step    (step)
    );

    assign key_rise  = key_s2_p1 & ~key_prev_p2;
    assign state_chg = (state_d != state_q);

    // Two-flop synchroniser for the asynchronous Enter key, then edge history.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_s1_p0   <= 1'b0;
            key_s2_p1   <= 1'b0;
            key_prev_p2 <= 1'b0;
        end else begin
            key_s1_p0   <= bus.start_key;
            key_s2_p1   <= key_s1_p0;
            key_prev_p2 <= key_s2_p1;
        end
    end

    // Next state and brightness; a key press beats a same-cycle fade step.
    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        unique case (state_q)
            FADE_IN: begin
                if (key_rise) begin
                    state_d = FADE_OUT;
                end else if (step) begin
                    bright_d = bright_q + 5'd1;
                    if (bright_d == BRIGHT_TOP) state_d = SHOW;
                end
            end
            SHOW: begin
                if (key_rise) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                if (step) begin
                    bright_d = bright_q - 5'd1;
                    if (bright_d == 5'd0) state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase
    end

    // State, brightness and the single-cycle hand-off pulse on entering DONE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= FADE_IN;
            bright_q     <= 5'd0;
            start_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bright_q     <= bright_d;
            start_done_q <= (state_d == DONE) && (state_q != DONE);
        end
    end

`ifdef START_SCREEN_BLINK_EN
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_HALF - 1);

    logic [5:0] blink_cnt;
    logic       blink_hidden;

    // Blink phase runs only in SHOW; any other state holds it visible.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (state_q != SHOW) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                blink_hidden <= ~blink_hidden;
            end else begin
                blink_cnt <= blink_cnt + 6'd1;
            end
        end
    end

    assign mask_yellow = (state_q == SHOW) && blink_hidden;
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign mask_yellow = 1'b0;
`endif

    assign pal = PALETTE[bus.color_idx];

    // Pixel stage: one-cycle palette lookup and brightness scaling.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_p0   <= 8'd0;
            green_p0 <= 8'd0;
            blue_p0  <= 8'd0;
        end else if (!bus.blank || state_q == DONE ||
                     (mask_yellow && bus.color_idx == IDX_YELLOW)) begin
            red_p0   <= 8'd0;
            green_p0 <= 8'd0;
            blue_p0  <= 8'd0;
        end else begin
            red_p0   <= scale_chan(pal[23:16], bright_q);
            green_p0 <= scale_chan(pal[15:8],  bright_q);
            blue_p0  <= scale_chan(pal[7:0],   bright_q);
        end
    end

    assign bus.Red           = red_p0;
    assign bus.Green         = green_p0;
    assign bus.Blue          = blue_p0;
    assign bus.screen_active = (state_q != DONE);
    assign bus.start_done    = start_done_q;

endmodule
